exit_arbiter: RTL and testbench

Merges exit requests from several harts or testbench agents into a single, ordered shutdown and drives the 9-bit `{finish, exitcode}` argument of the simulation-exit extension module. Requests are collected through a valid/ready handshake, and the exit codes are merged. The block then waits a fixed drain window so that console/UART output can flush. It issues exactly one finish pulse and stays locked until reset.

---
 rtl/exit_arbiter_if.sv | 30 +++
 rtl/exit_arbiter.sv | 158 +++++++++++++++
 tb/tb_exit_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/exit_arbiter_if.sv
// ----------------------------------------------------------------------------
// exit_arbiter_if : requester handshake and exit-argument bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface exit_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_code;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   accepted;
  logic [8:0]        finish_arg;
  logic              busy;
  logic              done;
  logic              timed_out;

  modport master (
    output req_valid, req_code,
    input  req_ready, accepted, finish_arg, busy, done, timed_out
  );

  modport slave (
    input  req_valid, req_code,
    output req_ready, accepted, finish_arg, busy, done, timed_out
  );
endinterface

`default_nettype wire

// File: rtl/exit_arbiter.sv
// ----------------------------------------------------------------------------
// exit_arbiter : merges exit requests into one drained, single finish pulse
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exit_arbiter #(
  parameter int         NREQ            = 2,
  parameter bit         WAIT_ALL        = 1'b1,
  parameter int         COLLECT_TIMEOUT = 1024,
  parameter int         DRAIN_CYCLES    = 16,
  parameter logic [7:0] TIMEOUT_CODE    = 8'hFE
) (
  input  logic          clk,
  input  logic          rst_n,
  exit_arbiter_if.slave bus
);

  localparam int TW = $clog2(COLLECT_TIMEOUT + 1);
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(COLLECT_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(COLLECT_TIMEOUT);
  localparam logic [DW-1:0] D_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [DW-1:0] D_MAX  = DW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_DRAIN   = 3'd2,
    S_FIRE    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state;
  logic [NREQ-1:0] accepted;
  logic [7:0]      code;
  logic            code_set;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   dcnt;
  logic [8:0]      finish_arg;
  logic            busy;
  logic            done;
  logic            timed_out;

  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] accept;
  logic [NREQ-1:0] accepted_nxt;
  logic            all_acc;
  logic            pick_valid;
  logic [7:0]      pick_code;
  logic            code_set_nxt;
  logic [7:0]      code_nxt;
  logic            timeout_hit;
  logic            go_drain;
  logic [7:0]      code_merge;
  logic [7:0]      req_code_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_codes
    assign req_code_arr[i] = bus.req_code[8*i +: 8];
  end

  assign ready = (state == S_IDLE || state == S_COLLECT) ? ~accepted : '0;

  always_comb begin
    accept       = bus.req_valid & ready;
    accepted_nxt = accepted | accept;
    all_acc      = &accepted_nxt;
    pick_valid   = 1'b0;
    pick_code    = 8'h00;
    // Scan downward so the lowest-index nonzero code wins a simultaneous accept
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (accept[i] && (req_code_arr[i] != 8'h00)) begin
        pick_valid = 1'b1;
        pick_code  = req_code_arr[i];
      end
    end
    code_set_nxt = code_set | pick_valid;
    code_nxt     = (!code_set && pick_valid) ? pick_code : code;
    timeout_hit  = (state == S_COLLECT) && !all_acc && (tcnt == T_LAST);
    code_merge   = (timeout_hit && !code_set_nxt) ? TIMEOUT_CODE : code_nxt;
    go_drain     = ((state == S_IDLE) && (|accept) && (!WAIT_ALL || all_acc)) ||
                   ((state == S_COLLECT) && (all_acc || (tcnt == T_LAST)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      accepted   <= '0;
      code       <= 8'h00;
      code_set   <= 1'b0;
      tcnt       <= '0;
      dcnt       <= '0;
      finish_arg <= 9'h000;
      busy       <= 1'b0;
      done       <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_COLLECT: begin
          accepted <= accepted_nxt;
          code     <= code_merge;
          code_set <= code_set_nxt;
          if (timeout_hit) begin
            timed_out <= 1'b1;
          end
          if (go_drain) begin
            busy <= 1'b1;
            // A zero-length drain fires straight from the entering edge
            if (DRAIN_CYCLES == 0) begin
              state      <= S_FIRE;
              finish_arg <= {1'b1, code_merge};
            end else begin
              state <= S_DRAIN;
              dcnt  <= '0;
            end
          end else if ((state == S_IDLE) && (|accept)) begin
            state <= S_COLLECT;
            tcnt  <= '0;
            busy  <= 1'b1;
          end else if ((state == S_COLLECT) && (tcnt != T_MAX)) begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (dcnt == D_LAST) begin
            state      <= S_FIRE;
            finish_arg <= {1'b1, code};
          end else if (dcnt != D_MAX) begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_FIRE: begin
          state      <= S_DONE;
          finish_arg <= 9'h000;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.accepted   = accepted;
  assign bus.finish_arg = finish_arg;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.timed_out  = timed_out;

endmodule

`default_nettype wire

// File: tb/tb_exit_arbiter.sv
// ----------------------------------------------------------------------------
// tb_exit_arbiter : scoreboard bench for exit_arbiter (collecting and immediate)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_exit_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   k;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  logic [8:0] exp_a;
  logic [8:0] exp_b;

  exit_arbiter_if #(.NREQ(2)) a_if();
  exit_arbiter_if #(.NREQ(2)) b_if();

  // Collecting configuration: wait for all, short timeout, 4-cycle drain
  exit_arbiter #(
    .NREQ(2), .WAIT_ALL(1'b1), .COLLECT_TIMEOUT(8), .DRAIN_CYCLES(4), .TIMEOUT_CODE(8'hFE)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if)
  );

  // Immediate configuration: first request fires with no drain
  exit_arbiter #(
    .NREQ(2), .WAIT_ALL(1'b0), .COLLECT_TIMEOUT(8), .DRAIN_CYCLES(0), .TIMEOUT_CODE(8'hFE)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_if.finish_arg[8] === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_extra_pulse", {23'd0, a_if.finish_arg}, 32'd0);
      end else begin
        exp_a = qa.pop_front();
        check("a_pulse", {23'd0, a_if.finish_arg}, {23'd0, exp_a});
      end
    end
    if (b_if.finish_arg[8] === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_extra_pulse", {23'd0, b_if.finish_arg}, 32'd0);
      end else begin
        exp_b = qb.pop_front();
        check("b_pulse", {23'd0, b_if.finish_arg}, {23'd0, exp_b});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    a_if.req_valid = '0;
    a_if.req_code  = '0;
    b_if.req_valid = '0;
    b_if.req_code  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Counts negedges from just after an accept edge until finish is seen high
  task automatic wait_pulse(input int which, output int cnt);
    cnt = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (((which == 0) ? a_if.finish_arg[8] : b_if.finish_arg[8]) === 1'b1) begin
        cnt = n;
        break;
      end
    end
    #1;
  endtask

  task automatic accept_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    a_if.req_valid = '0;
    a_if.req_code  = '0;
    b_if.req_valid = '0;
    b_if.req_code  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready",    {30'd0, a_if.req_ready}, 32'h3);
    check("rst_accepted", {30'd0, a_if.accepted}, 32'h0);
    check("rst_finish",   {23'd0, a_if.finish_arg}, 32'h0);
    check("rst_busy",     {31'd0, a_if.busy}, 32'h0);
    check("rst_done",     {31'd0, a_if.done}, 32'h0);
    check("rst_timedout", {31'd0, a_if.timed_out}, 32'h0);

    // Two requesters, both zero, four cycles apart
    do_reset();
    a_if.req_valid = 2'b01;
    a_if.req_code  = 16'h0000;
    accept_edge();
    a_if.req_valid = 2'b00;
    check("t1_acc0", {30'd0, a_if.accepted}, 32'h1);
    check("t1_busy", {31'd0, a_if.busy}, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    a_if.req_valid = 2'b10;
    qa.push_back(9'h100);
    accept_edge();
    a_if.req_valid = 2'b00;
    check("t1_acc11", {30'd0, a_if.accepted}, 32'h3);
    wait_pulse(0, k);
    check("t1_latency", k, 32'd5);
    @(negedge clk);
    check("t1_done",     {31'd0, a_if.done}, 32'h1);
    check("t1_fin_low",  {23'd0, a_if.finish_arg}, 32'h0);
    check("t1_busy_low", {31'd0, a_if.busy}, 32'h0);
    check("t1_ready0",   {30'd0, a_if.req_ready}, 32'h0);
    check("t1_no_tmo",   {31'd0, a_if.timed_out}, 32'h0);

    // Simultaneous nonzero codes: lowest index wins
    do_reset();
    a_if.req_valid = 2'b11;
    a_if.req_code  = {8'h07, 8'h03};
    qa.push_back(9'h103);
    accept_edge();
    a_if.req_valid = 2'b00;
    wait_pulse(0, k);
    check("t2a_latency", k, 32'd5);

    // Earlier nonzero code wins over a later lower index
    do_reset();
    a_if.req_valid = 2'b10;
    a_if.req_code  = {8'h07, 8'h00};
    qa.push_back(9'h107);
    accept_edge();
    a_if.req_valid = 2'b01;
    a_if.req_code  = {8'h00, 8'h03};
    accept_edge();
    a_if.req_valid = 2'b00;
    wait_pulse(0, k);
    check("t2b_latency", k, 32'd5);

    // Timeout with only a zero code
    do_reset();
    a_if.req_valid = 2'b01;
    a_if.req_code  = 16'h0000;
    qa.push_back(9'h1FE);
    accept_edge();
    a_if.req_valid = 2'b00;
    check("t3_tmo_early", {31'd0, a_if.timed_out}, 32'h0);
    wait_pulse(0, k);
    check("t3_latency", k, 32'd13);
    check("t3_tmo", {31'd0, a_if.timed_out}, 32'h1);

    // Immediate mode with no drain
    do_reset();
    b_if.req_valid = 2'b10;
    b_if.req_code  = {8'h2A, 8'h00};
    qb.push_back(9'h12A);
    accept_edge();
    b_if.req_valid = 2'b00;
    check("t4_fire",   {23'd0, b_if.finish_arg}, 32'h12A);
    check("t4_ready0", {30'd0, b_if.req_ready}, 32'h0);
    b_if.req_valid = 2'b01;
    b_if.req_code  = {8'h00, 8'h55};
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_late_acc", {30'd0, b_if.accepted}, 32'h2);
    check("t4_done",        {31'd0, b_if.done}, 32'h1);
    b_if.req_valid = 2'b00;

    // Reset during DRAIN drops everything, then a fresh request completes
    do_reset();
    a_if.req_valid = 2'b01;
    a_if.req_code  = {8'h00, 8'h05};
    accept_edge();
    a_if.req_valid = 2'b00;
    repeat (9) @(posedge clk);
    #2;
    check("t5_in_drain", {31'd0, a_if.busy}, 32'h1);
    check("t5_tmo_set",  {31'd0, a_if.timed_out}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy",     {31'd0, a_if.busy}, 32'h0);
    check("t5_rst_tmo",      {31'd0, a_if.timed_out}, 32'h0);
    check("t5_rst_accepted", {30'd0, a_if.accepted}, 32'h0);
    check("t5_rst_ready",    {30'd0, a_if.req_ready}, 32'h3);
    check("t5_rst_finish",   {23'd0, a_if.finish_arg}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_if.req_valid = 2'b11;
    a_if.req_code  = {8'h00, 8'h09};
    qa.push_back(9'h109);
    accept_edge();
    a_if.req_valid = 2'b00;
    wait_pulse(0, k);
    check("t5_latency", k, 32'd5);

    // Reset while the finish pulse is high, then hold requests in DONE
    do_reset();
    a_if.req_valid = 2'b11;
    a_if.req_code  = {8'h00, 8'h11};
    qa.push_back(9'h111);
    accept_edge();
    a_if.req_valid = 2'b00;
    wait_pulse(0, k);
    check("t6_latency", k, 32'd5);
    rst_n = 1'b0;
    #1;
    check("t6_fire_drop", {23'd0, a_if.finish_arg}, 32'h0);
    check("t6_rst_done",  {31'd0, a_if.done}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_if.req_valid = 2'b11;
    a_if.req_code  = {8'h22, 8'h00};
    qa.push_back(9'h122);
    accept_edge();
    wait_pulse(0, k);
    check("t6b_latency", k, 32'd5);
    repeat (20) @(posedge clk);
    #1;
    check("t6_done_hold", {31'd0, a_if.done}, 32'h1);
    check("t6_done_fin",  {23'd0, a_if.finish_arg}, 32'h0);
    a_if.req_valid = 2'b00;

    repeat (3) @(posedge clk);
    #1;
    check("sb_a_empty", qa.size(), 32'd0);
    check("sb_b_empty", qb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
